// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC core and its scan scheduler.
// Holds the conversion width, channel count, default SCLK divider and the
// scheduler state encoding.
package adc_pkg;

    localparam int unsigned ADC_BITS  = 12;
    localparam int unsigned ADC_CHANS = 8;
    localparam int unsigned ADC_CH_W  = 3;

    localparam logic [7:0] DIV_PARAM_DEF = 8'd13;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_NEXT  = 3'd4,
        S_GAP   = 3'd5
    } scan_state_t;

endpackage

// File: rtl/mask_next_ch.sv
// Combinational channel picker for the scan scheduler.
// Ports:
//   mask    - channel enable mask (bit i = channel i)
//   cur     - current channel index
//   next_ch - next set bit above cur, or the lowest set bit when none remain
//   wrap    - no set bit exists above cur
//   lowest  - lowest set bit of mask (0 when mask is empty)
module mask_next_ch
    import adc_pkg::*;
(
    input  logic [ADC_CHANS-1:0] mask,
    input  logic [2:0]           cur,
    output logic [2:0]           next_ch,
    output logic                 wrap,
    output logic [2:0]           lowest
);

    logic [2:0] idx;
    logic [2:0] above;
    logic       found;

    // Walk from the top bit down so the last hit is the lowest match.
    always_comb begin
        idx    = '0;
        lowest = '0;
        above  = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < ADC_CHANS; i++) begin
            idx = 3'(ADC_CHANS - 1 - i);
            if (mask[idx]) begin
                lowest = idx;
                if (idx > cur) begin
                    above = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign wrap    = ~found;
    assign next_ch = found ? above : lowest;

endmodule

// File: rtl/adc_scan_scheduler.sv
// Scan scheduler for the 8-channel serial ADC core.
// Walks the enabled channels one conversion at a time, optionally averaging
// 2^AVG_LOG2 conversions per channel, and keeps the latest result of each
// channel in a register bank. Supports single and continuous scans with an
// idle gap between passes.
// Ports:
//   clk_50mhz, rst           - clock, synchronous active-high reset
//   scan_start, scan_stop    - start / stop-after-current-conversion pulses
//   continuous, chan_mask,
//   gap_cycles               - scan configuration
//   adc_en, adc_channel,
//   adc_div                  - drive the ADC core's en / channel / div_param
//   adc_done, adc_data       - conversion result from the ADC core
//   rd_addr, rd_data         - combinational result-bank read
//   sample_valid, sample_chan- pulse and channel for each bank write
//   scan_done                - pulse at the end of each full pass
//   busy                     - scheduler not idle
//   timeout_err              - sticky conversion timeout flag
module adc_scan_scheduler #(
    parameter logic [7:0]  DIV_PARAM = adc_pkg::DIV_PARAM_DEF,
    parameter int unsigned AVG_LOG2  = 2,
    parameter logic [15:0] TIMEOUT   = 16'd2000
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        scan_start,
    input  logic        scan_stop,
    input  logic        continuous,
    input  logic [7:0]  chan_mask,
    input  logic [15:0] gap_cycles,
    output logic        adc_en,
    output logic [2:0]  adc_channel,
    output logic [7:0]  adc_div,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic        sample_valid,
    output logic [2:0]  sample_chan,
    output logic        scan_done,
    output logic        busy,
    output logic        timeout_err
);

    import adc_pkg::*;

    localparam int unsigned ACC_W = ADC_BITS + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    scan_state_t          state;
    logic [7:0]           mask_q;
    logic [2:0]           cur_ch;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     avg_cnt;
    logic [15:0]          tmo_cnt;
    logic [15:0]          gap_cnt;
    logic                 stop_pend;
    logic                 timeout_q;
    logic [ADC_BITS-1:0]  result [ADC_CHANS];

    logic [7:0]           mask_sel;
    logic [2:0]           nxt_ch;
    logic                 nxt_wrap;
    logic [2:0]           low_ch;
    logic                 avg_last;
    logic                 stop_now;
    logic [ADC_BITS-1:0]  avg_value;

    // One picker serves all three users: NEXT walks the latched mask, while
    // IDLE and the end of GAP need the lowest bit of the live mask.
    assign mask_sel = (state == S_NEXT) ? mask_q : chan_mask;

    mask_next_ch u_pick (
        .mask    (mask_sel),
        .cur     (cur_ch),
        .next_ch (nxt_ch),
        .wrap    (nxt_wrap),
        .lowest  (low_ch)
    );

    assign avg_last  = (avg_cnt == AVG_LAST);
    assign stop_now  = stop_pend | scan_stop;
    assign avg_value = acc[ACC_W-1 -: ADC_BITS];

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            cur_ch    <= '0;
            acc       <= '0;
            avg_cnt   <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            timeout_q <= 1'b0;
            for (int unsigned i = 0; i < ADC_CHANS; i++) begin
                result[i] <= '0;
            end
        end else begin
            if (state != S_IDLE && scan_stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    if (scan_start && (chan_mask != '0)) begin
                        mask_q    <= chan_mask;
                        cur_ch    <= low_ch;
                        acc       <= '0;
                        avg_cnt   <= '0;
                        timeout_q <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Reload one short so the flag lands TIMEOUT+1 edges after adc_en rises.
                    tmo_cnt <= TIMEOUT - 16'd1;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (adc_done) begin
                        acc   <= acc + ACC_W'(adc_data);
                        state <= S_STORE;
                    end else if (tmo_cnt == '0) begin
                        // A lost conversion counts as zero toward the average.
                        timeout_q <= 1'b1;
                        state     <= S_STORE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 16'd1;
                    end
                end
                S_STORE: begin
                    if (avg_last) begin
                        result[cur_ch] <= avg_value;
                        acc            <= '0;
                        avg_cnt        <= '0;
                        state          <= stop_now ? S_IDLE : S_NEXT;
                    end else if (stop_now) begin
                        acc     <= '0;
                        avg_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        avg_cnt <= avg_cnt + CNT_W'(1);
                        state   <= S_REQ;
                    end
                end
                S_NEXT: begin
                    cur_ch <= nxt_ch;
                    if (!nxt_wrap) begin
                        state <= stop_now ? S_IDLE : S_REQ;
                    end else if (continuous && !stop_now) begin
                        if (gap_cycles == '0) begin
                            state <= S_REQ;
                        end else begin
                            gap_cnt <= gap_cycles - 16'd1;
                            state   <= S_GAP;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (stop_now) begin
                        state <= S_IDLE;
                    end else if (gap_cnt == '0) begin
                        mask_q <= chan_mask;
                        cur_ch <= low_ch;
                        state  <= (chan_mask != '0) ? S_REQ : S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign adc_en       = (state == S_REQ);
    assign adc_channel  = cur_ch;
    assign adc_div      = DIV_PARAM;
    assign sample_valid = (state == S_STORE) && avg_last;
    assign sample_chan  = cur_ch;
    assign scan_done    = (state == S_NEXT) && nxt_wrap;
    assign busy         = (state != S_IDLE);
    assign timeout_err  = timeout_q;
    assign rd_data      = result[rd_addr];

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler: instance A (no averaging,
// short timeout) covers scans, gaps, stops, timeouts and reset; instance B
// (4x averaging) covers the accumulator.
module tb_adc_scan_scheduler;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst;

    // Instance A
    logic        a_start, a_stop, a_cont;
    logic [7:0]  a_mask;
    logic [15:0] a_gap;
    logic        a_en;
    logic [2:0]  a_ch;
    logic [7:0]  a_div;
    logic        a_done;
    logic [11:0] a_data;
    logic [2:0]  a_rd_addr;
    logic [11:0] a_rd_data;
    logic        a_sv;
    logic [2:0]  a_sch;
    logic        a_sdone, a_busy, a_terr;

    // Instance B
    logic        b_start, b_stop, b_cont;
    logic [7:0]  b_mask;
    logic [15:0] b_gap;
    logic        b_en;
    logic [2:0]  b_ch;
    logic [7:0]  b_div;
    logic        b_done;
    logic [11:0] b_data;
    logic [2:0]  b_rd_addr;
    logic [11:0] b_rd_data;
    logic        b_sv;
    logic [2:0]  b_sch;
    logic        b_sdone, b_busy, b_terr;

    adc_scan_scheduler #(
        .AVG_LOG2 (0),
        .TIMEOUT  (16'd100)
    ) dut_a (
        .clk_50mhz    (clk),
        .rst          (rst),
        .scan_start   (a_start),
        .scan_stop    (a_stop),
        .continuous   (a_cont),
        .chan_mask    (a_mask),
        .gap_cycles   (a_gap),
        .adc_en       (a_en),
        .adc_channel  (a_ch),
        .adc_div      (a_div),
        .adc_done     (a_done),
        .adc_data     (a_data),
        .rd_addr      (a_rd_addr),
        .rd_data      (a_rd_data),
        .sample_valid (a_sv),
        .sample_chan  (a_sch),
        .scan_done    (a_sdone),
        .busy         (a_busy),
        .timeout_err  (a_terr)
    );

    adc_scan_scheduler #(
        .DIV_PARAM (8'd7),
        .AVG_LOG2  (2)
    ) dut_b (
        .clk_50mhz    (clk),
        .rst          (rst),
        .scan_start   (b_start),
        .scan_stop    (b_stop),
        .continuous   (b_cont),
        .chan_mask    (b_mask),
        .gap_cycles   (b_gap),
        .adc_en       (b_en),
        .adc_channel  (b_ch),
        .adc_div      (b_div),
        .adc_done     (b_done),
        .adc_data     (b_data),
        .rd_addr      (b_rd_addr),
        .rd_data      (b_rd_data),
        .sample_valid (b_sv),
        .sample_chan  (b_sch),
        .scan_done    (b_sdone),
        .busy         (b_busy),
        .timeout_err  (b_terr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural ADC A: fixed per-channel data, done five negedges after en.
    function automatic logic [11:0] chan_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return 12'hA5A;
            3'd5:    return 12'h123;
            default: return 12'h300 + 12'(ch);
        endcase
    endfunction

    logic       a_mute = 1'b0;
    logic       a_pend = 1'b0;
    int         a_cnt  = 0;
    logic [2:0] a_req_ch = '0;

    always @(negedge clk) begin
        a_done = 1'b0;
        if (rst || a_mute) begin
            a_pend = 1'b0;
        end else if (a_pend) begin
            if (a_cnt == 0) begin
                a_done = 1'b1;
                a_data = chan_val(a_req_ch);
                a_pend = 1'b0;
            end else begin
                a_cnt--;
            end
        end
        if (a_en === 1'b1 && !rst) begin
            a_pend   = ~a_mute;
            a_cnt    = 4;
            a_req_ch = a_ch;
        end
    end

    // Behavioural ADC B: returns queued values in order.
    logic [11:0] b_q[$];
    logic        b_pend = 1'b0;
    int          b_cnt  = 0;

    always @(negedge clk) begin
        b_done = 1'b0;
        if (rst) begin
            b_pend = 1'b0;
        end else if (b_pend) begin
            if (b_cnt == 0) begin
                b_done = 1'b1;
                b_data = (b_q.size() != 0) ? b_q.pop_front() : 12'hFFF;
                b_pend = 1'b0;
            end else begin
                b_cnt--;
            end
        end
        if (b_en === 1'b1 && !rst) begin
            b_pend = 1'b1;
            b_cnt  = 2;
        end
    end

    // Scoreboard for instance A: expected channel per adc_en, expected bank write per sample_valid.
    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
    } samp_t;

    logic [2:0]  chq[$];
    samp_t       sq[$];
    int          en_cnt = 0, sv_cnt = 0, done_cnt = 0;
    int          b_en_cnt = 0, b_sv_cnt = 0, b_done_cnt = 0;
    logic        rd_pend = 1'b0;
    logic [11:0] rd_exp = '0;

    task automatic expect_scan(input logic [7:0] mask);
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                chq.push_back(3'(i));
                sq.push_back('{ch: 3'(i), val: chan_val(3'(i))});
            end
        end
    endtask

    task automatic tick();
        logic [2:0] ech;
        samp_t      s;
        @(negedge clk);
        if (rd_pend) begin
            rd_pend = 1'b0;
            check("bank_after_store", a_rd_data, rd_exp);
        end
        if (a_en === 1'b1) begin
            en_cnt++;
            check("adc_en_expected", 32'(chq.size() != 0), 1);
            if (chq.size() != 0) begin
                ech = chq.pop_front();
                check("adc_channel", a_ch, ech);
            end
        end
        if (a_sv === 1'b1) begin
            sv_cnt++;
            check("sample_expected", 32'(sq.size() != 0), 1);
            if (sq.size() != 0) begin
                s = sq.pop_front();
                check("sample_chan", a_sch, s.ch);
                a_rd_addr = s.ch;
                rd_exp    = s.val;
                rd_pend   = 1'b1;
            end
        end
        if (a_sdone === 1'b1) done_cnt++;
        if (b_en === 1'b1) begin
            b_en_cnt++;
            check("b_adc_channel", b_ch, 0);
        end
        if (b_sv === 1'b1) b_sv_cnt++;
        if (b_sdone === 1'b1) b_done_cnt++;
    endtask

    task automatic start_a(input logic [7:0] mask);
        a_mask  = mask;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (a_busy && n < budget);
        tick();
        check("busy_low_at_end", a_busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adc_en"}, a_en, 0);
        check({tag, "_adc_channel"}, a_ch, 0);
        check({tag, "_sample_valid"}, a_sv, 0);
        check({tag, "_sample_chan"}, a_sch, 0);
        check({tag, "_scan_done"}, a_sdone, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_timeout_err"}, a_terr, 0);
        for (int i = 0; i < 8; i++) begin
            a_rd_addr = 3'(i);
            #1;
            check({tag, "_bank_zero"}, a_rd_data, 0);
        end
    endtask

    typedef struct {
        logic [7:0] mask;
        int         exp_en;
        int         exp_done;
    } vec_t;

    vec_t vt[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s0, d0, n;
        vt[0] = '{mask: 8'b0010_0001, exp_en: 2, exp_done: 1};
        vt[1] = '{mask: 8'h00,        exp_en: 0, exp_done: 0};
        vt[2] = '{mask: 8'hFF,        exp_en: 8, exp_done: 1};
        vt[3] = '{mask: 8'h80,        exp_en: 1, exp_done: 1};
        vt[4] = '{mask: 8'b0101_0100, exp_en: 3, exp_done: 1};

        rst = 1'b1;
        a_start = 0; a_stop = 0; a_cont = 0; a_mask = 0; a_gap = 0; a_rd_addr = 0;
        b_start = 0; b_stop = 0; b_cont = 0; b_mask = 0; b_gap = 0; b_rd_addr = 0;
        a_data = 0; b_data = 0;
        repeat (3) tick();
        check_reset_outputs("por");
        check("adc_div_default", a_div, 8'd13);
        check("adc_div_override", b_div, 8'd7);
        check("b_busy_reset", b_busy, 0);
        rst = 1'b0;
        tick();

        // Table-driven single scans, no averaging.
        foreach (vt[i]) begin
            expect_scan(vt[i].mask);
            e0 = en_cnt; s0 = sv_cnt; d0 = done_cnt;
            start_a(vt[i].mask);
            run_idle(400);
            check("vec_en_count", 32'(en_cnt - e0), 32'(vt[i].exp_en));
            check("vec_sample_count", 32'(sv_cnt - s0), 32'(vt[i].exp_en));
            check("vec_scan_done_count", 32'(done_cnt - d0), 32'(vt[i].exp_done));
            check("vec_queues_drained", 32'(chq.size() + sq.size()), 0);
            if (i == 0) begin
                a_rd_addr = 3'd0; #1;
                check("result0_A5A", a_rd_data, 12'hA5A);
                a_rd_addr = 3'd5; #1;
                check("result5_123", a_rd_data, 12'h123);
            end
        end

        // Averaging on instance B: 100,200,300,400 -> 250; 5,6,7,9 -> 6 (truncated).
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                b_q.push_back(12'd100); b_q.push_back(12'd200);
                b_q.push_back(12'd300); b_q.push_back(12'd400);
            end else begin
                b_q.push_back(12'd5); b_q.push_back(12'd6);
                b_q.push_back(12'd7); b_q.push_back(12'd9);
            end
            e0 = b_en_cnt; s0 = b_sv_cnt; d0 = b_done_cnt;
            b_mask = 8'h01;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            n = 0;
            while (b_busy && n < 300) begin
                tick();
                n++;
            end
            check("avg_busy_low", b_busy, 0);
            check("avg_en_count", 32'(b_en_cnt - e0), 4);
            check("avg_sample_count", 32'(b_sv_cnt - s0), 1);
            check("avg_scan_done_count", 32'(b_done_cnt - d0), 1);
            b_rd_addr = 3'd0; #1;
            check("avg_result", b_rd_data, (r == 0) ? 12'd250 : 12'd6);
            check("avg_no_timeout", b_terr, 0);
        end

        // Continuous scan, 50-cycle gap, stop during the third conversion.
        a_cont = 1'b1;
        a_gap  = 16'd50;
        expect_scan(8'h80); expect_scan(8'h80); expect_scan(8'h80);
        s0 = sv_cnt; d0 = done_cnt;
        start_a(8'h80);
        n = 0;
        while (done_cnt == d0 && n < 300) begin tick(); n++; end
        check("cont_first_done", 32'(done_cnt != d0), 1);
        e0 = en_cnt; n = 0;
        while (en_cnt == e0 && n < 300) begin tick(); n++; end
        check("gap_length", 32'(n - 1), 50);
        n = 0;
        while (done_cnt < d0 + 2 && n < 300) begin tick(); n++; end
        check("cont_second_done", 32'(done_cnt - d0), 2);
        e0 = en_cnt; n = 0;
        while (en_cnt == e0 && n < 300) begin tick(); n++; end
        check("cont_third_req", 32'(en_cnt - e0), 1);
        tick(); tick();
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        run_idle(300);
        check("stop_third_stored", 32'(sv_cnt - s0), 3);
        check("stop_no_third_done", 32'(done_cnt - d0), 2);
        check("stop_queues_drained", 32'(chq.size() + sq.size()), 0);
        a_cont = 1'b0;

        // Timeout: ADC never answers, both channels store zero.
        a_mute = 1'b1;
        chq.push_back(3'd0); chq.push_back(3'd1);
        sq.push_back('{ch: 3'd0, val: 12'h000});
        sq.push_back('{ch: 3'd1, val: 12'h000});
        e0 = en_cnt;
        start_a(8'h03);
        n = 0;
        while (!a_terr && n < 300) begin tick(); n++; end
        check("timeout_latency", 32'(n), 101);
        run_idle(600);
        check("timeout_sticky", a_terr, 1);
        check("timeout_next_channel", 32'(en_cnt - e0), 2);
        a_mute = 1'b0;
        expect_scan(8'h01);
        start_a(8'h01);
        check("timeout_cleared_by_start", a_terr, 0);
        run_idle(300);

        // Ignored starts: empty mask, and start while busy.
        e0 = en_cnt;
        start_a(8'h00);
        repeat (10) tick();
        check("empty_mask_no_en", 32'(en_cnt - e0), 0);
        check("empty_mask_idle", a_busy, 0);
        expect_scan(8'b0010_0001);
        e0 = en_cnt; d0 = done_cnt;
        start_a(8'b0010_0001);
        repeat (3) tick();
        a_mask  = 8'hFF;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        run_idle(400);
        check("busy_start_en_count", 32'(en_cnt - e0), 2);
        check("busy_start_done_count", 32'(done_cnt - d0), 1);
        check("busy_start_queues", 32'(chq.size() + sq.size()), 0);

        // Reset during WAIT, then a clean scan.
        expect_scan(8'b0010_0001);
        start_a(8'b0010_0001);
        tick(); tick();
        chq.delete();
        sq.delete();
        rd_pend = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        expect_scan(8'b0010_0001);
        s0 = sv_cnt;
        start_a(8'b0010_0001);
        run_idle(400);
        check("post_reset_samples", 32'(sv_cnt - s0), 2);
        a_rd_addr = 3'd5; #1;
        check("post_reset_result5", a_rd_data, 12'h123);
        check("post_reset_queues", 32'(chq.size() + sq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
